maxpool_seq: RTL and testbench
==============================

# maxpool_seq

Frame-level sequencer for 2×2/stride-2 max pooling over a raster-ordered convolution output stream. It sits between the convolution accumulator output and the layer writeback. It tracks row and column position, pairs horizontal neighbours, and holds one row of pair-maxima in an internal line buffer. It emits one pooled word per 2×2 window, or passes the stream through unpooled when pooling is disabled for the frame.

## Interface
- `DWIDTH`, 20, data word width; values are signed two's complement.
- `IMG_W`, 24, input frame width in pixels; must be even and ≥2.
- `IMG_H`, 24, input frame height in rows; must be even and ≥2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle frame start request; honoured only in IDLE.
- `en_maxpool`  in  1  pooling enable; sampled only on an honoured `start`.
- `data_in`  in  DWIDTH  input pixel, raster order (row-major).
- `valid_in`  in  1  `data_in` qualifier; gaps are allowed.
- `data_out`  out  DWIDTH  pooled word, or bypassed pixel.
- `valid_out`  out  1  one-cycle qualifier for `data_out`.
- `busy`  out  1  high while the frame is running (state RUN).
- `done`  out  1  one-cycle pulse after the frame's last output.

## Operation
- **States: IDLE, RUN, DONE.**
  - IDLE → RUN on `start`: clears col/row counters, latches `en_maxpool` into `pool_mode`.
  - RUN → DONE when the pixel at (IMG_H-1, IMG_W-1) is accepted.
  - DONE → IDLE unconditionally after one cycle.
- **Pixel acceptance:** a pixel is accepted when `valid_in`=1 in RUN.
  - `valid_in` is ignored in IDLE and DONE.
  - `start` is ignored outside IDLE.
- **Counters:** col increments per accepted pixel and wraps at IMG_W-1 to 0, which increments row.
- **Pool mode, `pool_mode`=1:**
  - Even col: store pixel in hold register.
  - Odd col: `hmax` = signed max(hold, `data_in`).
  - Even row, odd col: write `hmax` to line buffer entry col>>1 (IMG_W/2 entries × DWIDTH).
  - Odd row, odd col: `data_out` = signed max(`linebuf`[col>>1], `hmax`); `valid_out` asserted.
- **Equal operands:** either operand may be selected, since the value is identical.
- **Output count:** exactly (IMG_W/2)·(IMG_H/2) words per frame, in raster order of windows.
- **Bypass mode, `pool_mode`=0:** every accepted pixel is forwarded unchanged; IMG_W·IMG_H outputs per frame.
- **Buffer contents:** the line buffer is not reset; every entry read in a frame was written earlier in the same frame.

## Timing
- **Reset values:** `data_out`=0, `valid_out`=0, `busy`=0, `done`=0, state IDLE, counters 0, `pool_mode`=0, hold register 0.
- **Latency:** `data_out`/`valid_out` are registered and appear the cycle after the triggering pixel is accepted, in both modes.
- **`busy`:** rises the cycle after an honoured `start` and falls the cycle `done` rises.
- **`done`:** high for exactly one cycle (state DONE). This is the same cycle as the final `valid_out`, since the final output is registered from the last accepted pixel.
- **`start` and `valid_in` together in IDLE:** the pixel is not accepted; the first accepted pixel is on the next valid cycle in RUN.
- **Stalls:** `valid_in` low holds all counters and hold/buffer state; no output is generated.
- **`valid_out` outside RUN:** `valid_out` is never high except on the cycle after an accepted triggering pixel.
- **Reset mid-frame:** immediate return to IDLE with all outputs at reset values; the partial frame is discarded, and the next `start` begins a clean frame.
- **Back-to-back frames:** `start` may be asserted in the cycle after DONE (state IDLE) with no dead cycles beyond that.

## Configuration
- **`MAXPOOL_RELU_EN` defined:** every value driven onto `data_out` (both modes) is clamped to 0 if negative (sign bit set). Pooling comparisons still use unclamped signed values.
- **`MAXPOOL_RELU_EN` undefined:** outputs are the raw signed max, or the raw pixel in bypass mode.

## Test plan
- **Basic pooling:** IMG_W=4, IMG_H=4, `en_maxpool`=1, pixels 0..15 streamed back-to-back → `valid_out` pulses carrying 5, 7, 13, 15. `done` pulses on the cycle of the output 15; `busy` then low.
- **Signed compare:** 4×4 frame, window {-3, -8, -1, -20} in the top-left, all other pixels -100 → first output -1. With `MAXPOOL_RELU_EN` defined: outputs 0, 0, 0, 0.
- **Bypass:** 4×4 frame, `en_maxpool`=0 at `start`, pixels 0..15 → 16 outputs 0..15, each one cycle after input. Toggling `en_maxpool` mid-frame has no effect.
- **Stalls:** basic pooling stimulus with `valid_in` low every other cycle → same outputs 5, 7, 13, 15 and the same count; no spurious `valid_out`.
- **Reset mid-frame:** assert `reset` after pixel 9 of frame 1, then restart and stream 16..31 → outputs 21, 23, 29, 31 only.
- **Ignored inputs:** `valid_in`=1 with data in IDLE, and a second `start` during RUN → no outputs from IDLE data; frame count and results unchanged.

Source files
------------

// File: rtl/maxpool_seq.sv
// 2x2 / stride-2 max-pooling sequencer with per-frame bypass for a raster-ordered pixel stream.
// Optional MAXPOOL_RELU_EN clamps negative values driven onto data_out to zero.
module maxpool_seq #(
    parameter int unsigned DWIDTH = 20,
    parameter int unsigned IMG_W  = 24,
    parameter int unsigned IMG_H  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              en_maxpool,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              valid_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              valid_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_D  = IMG_W / 2;
    localparam int unsigned HW    = (LB_D > 1) ? $clog2(LB_D) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_pool_mode;
    logic [DWIDTH-1:0] r_hold;
    logic [DWIDTH-1:0] r_linebuf [LB_D];

    logic              w_accept;
    logic              w_last_col;
    logic              w_last_row;
    logic [HW-1:0]     w_lb_idx;
    logic [DWIDTH-1:0] w_lb_rd;
    logic [DWIDTH-1:0] w_hmax;
    logic [DWIDTH-1:0] w_pool;

    function automatic logic [DWIDTH-1:0] f_out(input logic [DWIDTH-1:0] v);
`ifdef MAXPOOL_RELU_EN
        return v[DWIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Horizontal pair max, then vertical max against the buffered upper-row pair.
    assign w_accept   = (r_state == S_RUN) && valid_in;
    assign w_last_col = (r_col == CW'(IMG_W - 1));
    assign w_last_row = (r_row == RW'(IMG_H - 1));
    assign w_lb_idx   = HW'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_lb_idx];
    assign w_hmax     = ($signed(r_hold) > $signed(data_in)) ? r_hold : data_in;
    assign w_pool     = ($signed(w_lb_rd) > $signed(w_hmax)) ? w_lb_rd : w_hmax;

    // Line buffer holds pair maxima of the even row; it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept && r_pool_mode && r_col[0] && !r_row[0]) begin
            r_linebuf[w_lb_idx] <= w_hmax;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_pool_mode <= 1'b0;
            r_hold      <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_pool_mode <= en_maxpool;
                        busy        <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (valid_in) begin
                        if (!r_col[0]) begin
                            r_hold <= data_in;
                        end
                        if (!r_pool_mode) begin
                            data_out  <= f_out(data_in);
                            valid_out <= 1'b1;
                        end else if (r_col[0] && r_row[0]) begin
                            data_out  <= f_out(w_pool);
                            valid_out <= 1'b1;
                        end
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= w_last_row ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_last_col && w_last_row) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_seq.sv
// Bench for maxpool_seq on a 4x4 frame: directed test-plan frames plus random frames vs a window-max model.
module tb_maxpool_seq;

    localparam int unsigned DW = 20;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned NP = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          en_maxpool;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [DW-1:0] frame [NP];
    logic signed [DW-1:0] out_q [$];
    logic signed [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    maxpool_seq #(.DWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .en_maxpool (en_maxpool),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .busy       (busy),
        .done       (done)
    );

    // Capture every emitted word for frame-level comparison.
    always @(negedge clk) begin
        if (valid_out) out_q.push_back($signed(data_out));
    end

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
        end
    endtask

    // Expected outputs: max over each 2x2 window in raster order, or the raw pixels.
    task automatic build_model(input bit pool);
        logic signed [DW-1:0] m;
        exp_q.delete();
        if (pool) begin
            for (int wr = 0; wr < int'(H / 2); wr++) begin
                for (int wc = 0; wc < int'(W / 2); wc++) begin
                    m = frame[(2 * wr) * W + 2 * wc];
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++)
                            if (frame[(2 * wr + dy) * W + 2 * wc + dx] > m)
                                m = frame[(2 * wr + dy) * W + 2 * wc + dx];
                    exp_q.push_back(relu(m));
                end
            end
        end else begin
            for (int i = 0; i < int'(NP); i++) exp_q.push_back(relu(frame[i]));
        end
    endtask

    task automatic compare_frame(input string tag);
        int n;
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_word"}, out_q[i], exp_q[i]);
    endtask

    // stall: 0 none, 1 every other cycle, 2 random gaps. ign: valid at start cycle and a re-start mid-frame.
    task automatic send_frame(input bit en, input int stall, input bit toggle_en, input bit ign);
        out_q.delete();
        @(negedge clk);
        start      = 1'b1;
        en_maxpool = en;
        valid_in   = ign;
        data_in    = DW'(12345);
        @(negedge clk);
        start    = 1'b0;
        valid_in = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
            if (stall == 1) begin
                data_in = DW'($urandom);
                @(negedge clk);
            end else if (stall == 2) begin
                data_in = DW'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            data_in  = frame[i];
            valid_in = 1'b1;
            if (toggle_en) en_maxpool = ~en_maxpool;
            if (ign && i == 5) start = 1'b1;
            @(negedge clk);
            start    = 1'b0;
            valid_in = 1'b0;
            if (!en) begin
                chk("bypass_lat_valid", 32'(valid_out), 1);
                chk("bypass_lat_data", 32'($signed(data_out)), relu(frame[i]));
            end
            if (i == int'(NP) - 1) begin
                chk("done_pulse", 32'(done), 1);
                chk("last_valid_with_done", 32'(valid_out), 1);
                chk("busy_low_at_done", 32'(busy), 0);
            end else begin
                chk("busy_in_run", 32'(busy), 1);
            end
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
        chk("no_valid_after_done", 32'(valid_out), 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        en_maxpool = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        repeat (2) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 0);
        chk("reset_valid_out", 32'(valid_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        reset = 1'b0;

        // Basic pooling: windows of 0..15 give 5, 7, 13, 15.
        for (int i = 0; i < int'(NP); i++) frame[i] = DW'(i);
        send_frame(1'b1, 0, 1'b0, 1'b0);
        exp_q = {relu(DW'(5)), relu(DW'(7)), relu(DW'(13)), relu(DW'(15))};
        compare_frame("basic");

        // Signed compare with a negative top-left window.
        for (int i = 0; i < int'(NP); i++) frame[i] = DW'(-100);
        frame[0] = DW'(-3);
        frame[1] = DW'(-8);
        frame[4] = DW'(-1);
        frame[5] = DW'(-20);
        send_frame(1'b1, 0, 1'b0, 1'b0);
        build_model(1'b1);
        compare_frame("signed");

        // Bypass with en_maxpool toggling mid-frame.
        for (int i = 0; i < int'(NP); i++) frame[i] = DW'(i);
        send_frame(1'b0, 0, 1'b1, 1'b0);
        build_model(1'b0);
        compare_frame("bypass");

        // Alternating stalls.
        send_frame(1'b1, 1, 1'b0, 1'b0);
        build_model(1'b1);
        compare_frame("stalls");

        // Data in IDLE must produce nothing.
        out_q.delete();
        valid_in = 1'b1;
        repeat (3) begin
            data_in = DW'($urandom);
            @(negedge clk);
        end
        valid_in = 1'b0;
        @(negedge clk);
        chk("idle_no_output", out_q.size(), 0);
        chk("idle_not_busy", 32'(busy), 0);

        // Valid on the start cycle and a second start during RUN are ignored.
        send_frame(1'b1, 0, 1'b0, 1'b1);
        build_model(1'b1);
        compare_frame("ignored");

        // Reset after pixel 9, then a clean frame of 16..31.
        @(negedge clk);
        start      = 1'b1;
        en_maxpool = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in  = DW'(i);
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("midreset_data_out", 32'(data_out), 0);
        chk("midreset_valid_out", 32'(valid_out), 0);
        chk("midreset_busy", 32'(busy), 0);
        reset = 1'b0;
        for (int i = 0; i < int'(NP); i++) frame[i] = DW'(16 + i);
        send_frame(1'b1, 0, 1'b0, 1'b0);
        exp_q = {relu(DW'(21)), relu(DW'(23)), relu(DW'(29)), relu(DW'(31))};
        compare_frame("after_reset");

        // Random frames, random mode and random gaps, back to back.
        repeat (8) begin
            automatic bit en = 1'($urandom);
            for (int i = 0; i < int'(NP); i++) frame[i] = DW'($urandom);
            send_frame(en, 2, 1'b0, 1'b0);
            build_model(en);
            compare_frame(en ? "rand_pool" : "rand_bypass");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
